// File: rtl/banner_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// banner_scroll_ctrl
//
// Loads a short message of hex nibbles into a buffer, then scrolls it across
// a four-digit multiplexed display. Scrolling runs automatically off a
// prescaled tick or manually with single step pulses while paused. The
// scroll direction can advance or retreat. A message shorter than four
// digits repeats across the display.
//
// Parameters
//   N         : maximum message length in nibbles (4..16)
//   DVSR      : clk cycles per automatic scroll tick (>= 2)
//   REFRESH_W : width of the display refresh counter; its top two bits
//               select the digit being driven
//
// Ports
//   clk, reset_n        : clock (rising edge), async active-low reset
//   clear               : synchronous return to IDLE, highest priority
//   wr_valid/wr_data/
//   wr_last/wr_ready    : nibble write handshake for loading the message
//   run, dir, step      : auto-scroll enable, direction, manual step pulse
//   pos, msg_len        : current scroll offset and stored message length
//   active              : high while scrolling or paused
//   scroll_tick         : one-cycle pulse on each automatic move
//   an, digit_nib       : registered active-low digit enables and nibble
// ---------------------------------------------------------------------------
module banner_scroll_ctrl #(
  parameter int N         = 10,
  parameter int DVSR      = 50000000,
  parameter int REFRESH_W = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       wr_valid,
  input  logic [3:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  output logic [3:0] pos,
  output logic [4:0] msg_len,
  output logic       active,
  output logic       scroll_tick,
  output logic [3:0] an,
  output logic [3:0] digit_nib
);

  localparam int              PW        = $clog2(DVSR);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(DVSR - 1);
  localparam logic [4:0]      LAST_PTR  = 5'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL, PAUSE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [4:0]             wr_ptr;
  logic [PW-1:0]          presc;
  logic [REFRESH_W-1:0]   refresh;
  logic [1:0]             sel;
  logic [3:0]             msg_buf [16];
  logic                   accept;
  logic                   is_final;
  logic                   move_now;
  logic [3:0]             moved_pos;
  logic [4:0]             disp_idx;
  logic [3:0]             an_next;

  // One scroll step around the message ring; a one-nibble message never moves.
  function automatic logic [3:0] move_pos(input logic [3:0] p,
                                          input logic [4:0] len,
                                          input logic       d);
    if (len <= 5'd1)
      return p;
    if (!d)
      return ({1'b0, p} == len - 5'd1) ? 4'd0 : p + 4'd1;
    return (p == 4'd0) ? 4'(len - 5'd1) : p - 4'd1;
  endfunction

  assign wr_ready    = (state == IDLE) || (state == LOAD);
  assign active      = (state == SCROLL) || (state == PAUSE);
  assign accept      = wr_valid && wr_ready;
  // The last buffer slot always terminates the message, even without wr_last.
  assign is_final    = wr_last || (wr_ptr == LAST_PTR);
  assign scroll_tick = (state == SCROLL) && (presc == PRESC_MAX);
  assign move_now    = scroll_tick || ((state == PAUSE) && step);
  assign moved_pos   = move_pos(pos, msg_len, dir);
  assign sel         = refresh[REFRESH_W-1 -: 2];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: clear overrides everything, loading ends on the final
  // write, and run toggles between SCROLL and PAUSE.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept)
            state_next = is_final ? (run ? SCROLL : PAUSE) : LOAD;
        end
        LOAD: begin
          if (accept && is_final)
            state_next = run ? SCROLL : PAUSE;
        end
        SCROLL: begin
          if (!run)
            state_next = PAUSE;
        end
        PAUSE: begin
          if (run)
            state_next = SCROLL;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Write pointer, message length, scroll offset and prescaler. The
  // prescaler only advances in SCROLL so a pause keeps the partial interval.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos     <= '0;
      msg_len <= '0;
      wr_ptr  <= '0;
      presc   <= '0;
    end else if (clear) begin
      pos     <= '0;
      msg_len <= '0;
      wr_ptr  <= '0;
      presc   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 5'd1;
        if (is_final) begin
          msg_len <= wr_ptr + 5'd1;
          pos     <= '0;
        end
      end else if (state == IDLE) begin
        wr_ptr <= '0;
      end
      if (state == SCROLL)
        presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
      if (move_now)
        pos <= moved_pos;
    end
  end

  // Message storage; contents need no reset because nothing reads them
  // until a full message has been loaded.
  always_ff @(posedge clk) begin
    if (accept)
      msg_buf[wr_ptr[3:0]] <= wr_data;
  end

  // Free-running refresh counter that multiplexes the four digits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      refresh <= '0;
    else
      refresh <= refresh + REFRESH_W'(1);
  end

  // Buffer index for the selected digit: (pos + sel) mod msg_len. Since
  // pos < msg_len and sel <= 3, three conditional subtractions suffice even
  // for a one-nibble message.
  always_comb begin
    disp_idx = {1'b0, pos} + {3'b000, sel};
    for (int i = 0; i < 3; i++) begin
      if ((msg_len != 5'd0) && (disp_idx >= msg_len))
        disp_idx = disp_idx - msg_len;
    end
    case (sel)
      2'd0:    an_next = 4'b0111;
      2'd1:    an_next = 4'b1011;
      2'd2:    an_next = 4'b1101;
      default: an_next = 4'b1110;
    endcase
  end

  // Registered display drive; blanked outside SCROLL/PAUSE and on clear so
  // the display is dark in the first IDLE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an        <= 4'b1111;
      digit_nib <= '0;
    end else if (clear || !active) begin
      an        <= 4'b1111;
      digit_nib <= '0;
    end else begin
      an        <= an_next;
      digit_nib <= msg_buf[disp_idx[3:0]];
    end
  end

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_banner_scroll_ctrl
//
// Self-checking bench for banner_scroll_ctrl with DVSR=4, N=10 and a short
// refresh counter so every digit is reached quickly. A behavioural model
// tracks the message, offset, tick phase and refresh count with plain
// arithmetic; a compare process checks every output on each falling edge.
// Directed scenarios pin the model with hand-computed values, then a
// randomized run exercises the remaining interactions.
// ---------------------------------------------------------------------------
module tb_banner_scroll_ctrl;

  localparam int N              = 10;
  localparam int DVSR           = 4;
  localparam int REFRESH_W      = 6;
  localparam int REFRESH_PERIOD = 1 << REFRESH_W;
  localparam int SEL_SPAN       = REFRESH_PERIOD / 4;

  localparam int M_IDLE   = 0;
  localparam int M_LOAD   = 1;
  localparam int M_SCROLL = 2;
  localparam int M_PAUSE  = 3;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       clear    = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_data  = 4'h0;
  logic       wr_last  = 1'b0;
  logic       run      = 1'b0;
  logic       dir      = 1'b0;
  logic       step     = 1'b0;
  logic       wr_ready;
  logic [3:0] pos;
  logic [4:0] msg_len;
  logic       active;
  logic       scroll_tick;
  logic [3:0] an;
  logic [3:0] digit_nib;

  int   vec_count  = 0;
  int   miss_count = 0;
  bit   check_en   = 1'b0;
  logic run_lvl    = 1'b0;
  logic dir_lvl    = 1'b0;

  // Behavioural model state
  int         m_mode    = M_IDLE;
  int         m_pos     = 0;
  int         m_len     = 0;
  int         m_wp      = 0;
  int         m_phase   = 0;
  int         m_refresh = 0;
  int         m_an      = 15;
  int         m_dig     = 0;
  logic [3:0] m_buf [16];

  always #5 clk = ~clk;

  banner_scroll_ctrl #(
    .N         (N),
    .DVSR      (DVSR),
    .REFRESH_W (REFRESH_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_ready    (wr_ready),
    .run         (run),
    .dir         (dir),
    .step        (step),
    .pos         (pos),
    .msg_len     (msg_len),
    .active      (active),
    .scroll_tick (scroll_tick),
    .an          (an),
    .digit_nib   (digit_nib)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual != expected) begin
      miss_count++;
      $display("[TB] FAIL %s: actual %0d required %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle worth of inputs, let the next rising edge consume them,
  // and return just after that edge with the outputs settled.
  task automatic applyStimulus(input logic c, input logic v, input logic [3:0] d,
                               input logic l, input logic s);
    clear    = c;
    wr_valid = v;
    wr_data  = d;
    wr_last  = l;
    step     = s;
    run      = run_lvl;
    dir      = dir_lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_tick(input int budget, output int waited);
    waited = 0;
    while (scroll_tick !== 1'b1 && waited < budget) begin
      idle_cycle();
      waited++;
    end
    checkOutput("tick_seen", int'(scroll_tick), 1);
  endtask

  task automatic wait_an(input logic [3:0] pat, input int budget);
    int n;
    n = 0;
    while (an !== pat && n < budget) begin
      idle_cycle();
      n++;
    end
    checkOutput("an_reach", int'(an), int'(pat));
  endtask

  function automatic int advance(input int p, input int len, input logic d);
    return d ? (p + len - 1) % len : (p + 1) % len;
  endfunction

  // Model step on every rising clock edge and on reset assertion.
  task automatic model_step();
    int         nmode;
    int         sel;
    logic [3:0] en;
    if (!reset_n) begin
      m_mode    = M_IDLE;
      m_pos     = 0;
      m_len     = 0;
      m_wp      = 0;
      m_phase   = 0;
      m_refresh = 0;
      m_an      = 15;
      m_dig     = 0;
    end else begin
      if (clear || m_mode == M_IDLE || m_mode == M_LOAD) begin
        m_an  = 15;
        m_dig = 0;
      end else begin
        sel   = m_refresh / SEL_SPAN;
        en    = ~(4'b1000 >> sel);
        m_an  = int'(en);
        m_dig = int'(m_buf[(m_pos + sel) % m_len]);
      end
      m_refresh = (m_refresh + 1) % REFRESH_PERIOD;
      if (clear) begin
        m_mode  = M_IDLE;
        m_pos   = 0;
        m_len   = 0;
        m_wp    = 0;
        m_phase = 0;
      end else begin
        nmode = m_mode;
        if (m_mode == M_IDLE || m_mode == M_LOAD) begin
          if (wr_valid) begin
            m_buf[m_wp] = wr_data;
            if (wr_last || m_wp == N - 1) begin
              m_len = m_wp + 1;
              m_pos = 0;
              nmode = run ? M_SCROLL : M_PAUSE;
            end else begin
              nmode = M_LOAD;
            end
            m_wp++;
          end else if (m_mode == M_IDLE) begin
            m_wp = 0;
          end
        end else if (m_mode == M_SCROLL) begin
          if (m_phase == DVSR - 1)
            m_pos = advance(m_pos, m_len, dir);
          m_phase = (m_phase + 1) % DVSR;
          if (!run)
            nmode = M_PAUSE;
        end else begin
          if (step)
            m_pos = advance(m_pos, m_len, dir);
          if (run)
            nmode = M_SCROLL;
        end
        m_mode = nmode;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      model_step();
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("scroll_tick", int'(scroll_tick), int'(m_mode == M_SCROLL && m_phase == DVSR - 1));
        checkOutput("wr_ready", int'(wr_ready), int'(m_mode == M_IDLE || m_mode == M_LOAD));
        checkOutput("active", int'(active), int'(m_mode == M_SCROLL || m_mode == M_PAUSE));
        checkOutput("pos", int'(pos), m_pos);
        checkOutput("msg_len", int'(msg_len), m_len);
        checkOutput("an", int'(an), m_an);
        checkOutput("digit_nib", int'(digit_nib), m_dig);
      end
    end
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pos", int'(pos), 0);
    checkOutput("rst_len", int'(msg_len), 0);
    checkOutput("rst_an", int'(an), 15);
    checkOutput("rst_digit", int'(digit_nib), 0);
    checkOutput("rst_tick", int'(scroll_tick), 0);
    checkOutput("rst_active", int'(active), 0);
    reset_n  = 1'b1;
    check_en = 1'b1;
    checkOutput("ready_after_rst", int'(wr_ready), 1);

    $display("[TB] load 1..5 and auto-advance");
    run_lvl = 1'b1;
    dir_lvl = 1'b0;
    for (int i = 1; i <= 5; i++)
      applyStimulus(1'b0, 1'b1, 4'(i), (i == 5), 1'b0);
    checkOutput("load_active", int'(active), 1);
    checkOutput("load_len", int'(msg_len), 5);
    checkOutput("load_pos", int'(pos), 0);
    checkOutput("load_ready", int'(wr_ready), 0);
    for (int k = 1; k <= 5; k++) begin
      wait_tick(8, w);
      checkOutput("tick_interval", w, 3);
      idle_cycle();
      checkOutput("pos_adv", int'(pos), k % 5);
    end

    $display("[TB] retreat wrap and digit contents");
    dir_lvl = 1'b1;
    wait_tick(8, w);
    checkOutput("tick_interval", w, 3);
    idle_cycle();
    checkOutput("pos_retreat", int'(pos), 4);
    run_lvl = 1'b0;
    idle_cycle();
    checkOutput("pause_active", int'(active), 1);
    checkOutput("pause_pos", int'(pos), 4);
    wait_an(4'b0111, 80);
    checkOutput("digit0_pos4", int'(digit_nib), 5);
    wait_an(4'b1110, 80);
    checkOutput("digit3_pos4", int'(digit_nib), 3);

    $display("[TB] pause with two step pulses");
    dir_lvl = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("step1_pos", int'(pos), 0);
    checkOutput("step_no_tick", int'(scroll_tick), 0);
    idle_cycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("step2_pos", int'(pos), 1);
    idle_cycle();
    checkOutput("step_no_tick", int'(scroll_tick), 0);
    run_lvl = 1'b1;
    idle_cycle();
    wait_tick(8, w);
    checkOutput("resume_remainder", w, 2);
    idle_cycle();
    checkOutput("resume_pos", int'(pos), 2);

    $display("[TB] two-nibble message repeats");
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("clear_active", int'(active), 0);
    checkOutput("clear_len", int'(msg_len), 0);
    run_lvl = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hB, 1'b1, 1'b0);
    checkOutput("short_len", int'(msg_len), 2);
    wait_an(4'b0111, 80);
    checkOutput("short_d0", int'(digit_nib), 10);
    wait_an(4'b1011, 80);
    checkOutput("short_d1", int'(digit_nib), 11);
    wait_an(4'b1101, 80);
    checkOutput("short_d2", int'(digit_nib), 10);
    wait_an(4'b1110, 80);
    checkOutput("short_d3", int'(digit_nib), 11);

    $display("[TB] buffer overflow ends message");
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    run_lvl = 1'b1;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b1, 4'(i + 3), 1'b0, 1'b0);
    checkOutput("ovf_len", int'(msg_len), 10);
    checkOutput("ovf_ready", int'(wr_ready), 0);
    checkOutput("ovf_active", int'(active), 1);
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
    checkOutput("ovf_len_hold", int'(msg_len), 10);
    checkOutput("ovf_pos", int'(pos), 0);

    $display("[TB] clear on tick, reset mid-load");
    wait_tick(8, w);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("clr_tick_active", int'(active), 0);
    checkOutput("clr_tick_pos", int'(pos), 0);
    checkOutput("clr_tick_an", int'(an), 15);
    checkOutput("clr_tick_ready", int'(wr_ready), 1);
    applyStimulus(1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h8, 1'b0, 1'b0);
    checkOutput("midload_ready", int'(wr_ready), 1);
    checkOutput("midload_active", int'(active), 0);
    reset_n = 1'b0;
    #1;
    checkOutput("rst2_pos", int'(pos), 0);
    checkOutput("rst2_len", int'(msg_len), 0);
    checkOutput("rst2_active", int'(active), 0);
    checkOutput("rst2_tick", int'(scroll_tick), 0);
    checkOutput("rst2_an", int'(an), 15);
    checkOutput("rst2_digit", int'(digit_nib), 0);
    idle_cycle();
    reset_n = 1'b1;
    checkOutput("rst2_ready", int'(wr_ready), 1);
    applyStimulus(1'b0, 1'b1, 4'h9, 1'b1, 1'b0);
    checkOutput("single_len", int'(msg_len), 1);
    wait_tick(8, w);
    idle_cycle();
    checkOutput("single_pos", int'(pos), 0);

    $display("[TB] randomized run");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0)
        run_lvl = ~run_lvl;
      if ($urandom_range(0, 9) == 0)
        dir_lvl = ~dir_lvl;
      reset_n = ($urandom_range(0, 399) != 0);
      applyStimulus($urandom_range(0, 119) == 0, $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7) == 0);
    end
    reset_n = 1'b1;
    idle_cycle();
    idle_cycle();
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/banner_scroll_ctrl.md
BANNER_SCROLL_CTRL -- requirements
Module: banner_scroll_ctrl

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low; ports are clk and reset_n.
REQ-002 SHALL have parameter N, default 10, meaning maximum message length in nibbles; legal range 4..16.
REQ-003 SHALL have parameter DVSR, default 50000000, meaning clk cycles per scroll tick; minimum 2.
REQ-004 SHALL have ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  async active-low reset.
- clear  in  1  synchronous return to IDLE.
- wr_valid  in  1  nibble write request.
- wr_data  in  4  message nibble.
- wr_last  in  1  marks the final nibble of the message.
- wr_ready  out  1  write accept.
- run  in  1  level; 1 = auto-scroll, 0 = pause.
- dir  in  1  0 = advance, 1 = retreat.
- step  in  1  single-cycle pulse; one manual move while paused.
- pos  out  4  current scroll offset.
- msg_len  out  5  stored message length.
- active  out  1  state is SCROLL or PAUSE.
- scroll_tick  out  1  one-cycle pulse on each auto move.
- an  out  4  digit enables, active-low.
- digit_nib  out  4  nibble for the enabled digit.

Function
REQ-005 SHALL implement states IDLE, LOAD, SCROLL and PAUSE.
REQ-006 SHALL assert wr_ready only in IDLE and LOAD; a write is accepted when wr_valid and wr_ready are both 1 on a clock edge.
REQ-007 SHALL store the accepted nibble at buffer index wr_ptr, then increment wr_ptr; IDLE resets wr_ptr to 0.
REQ-008 SHALL leave IDLE on the first accepted write:
- to LOAD if that write is not the final one;
- directly to SCROLL (run=1) or PAUSE (run=0) if that write has wr_last=1.
REQ-009 SHALL treat a write as the final one when wr_last=1 or wr_ptr=N-1.
- On the final write: msg_len = wr_ptr+1, pos = 0, next state SCROLL if run=1, else PAUSE.
REQ-010 SHALL run the prescaler only in SCROLL, counting 0..DVSR-1 and wrapping.
- scroll_tick=1 in the cycle the prescaler equals DVSR-1.
- On that edge pos updates: dir=0 gives (pos+1) mod msg_len; dir=1 gives pos-1, with 0 wrapping to msg_len-1.
REQ-011 SHALL move from SCROLL to PAUSE when run=0; the prescaler holds its value and no tick is issued in PAUSE.
REQ-012 SHALL move from PAUSE to SCROLL when run=1; the prescaler resumes from its held value.
REQ-013 SHALL, in PAUSE, apply one move per step pulse using the REQ-010 arithmetic.
- step is ignored in SCROLL, IDLE and LOAD.
- step together with run=1 in PAUSE: the move is applied and the state becomes SCROLL.
REQ-014 SHALL give clear highest priority, in any state:
- next state IDLE;
- pos, msg_len, wr_ptr and prescaler all become 0;
- buffer contents are don't-care.
REQ-015 SHALL keep pos unchanged when msg_len=1, while still pulsing scroll_tick.
REQ-016 SHALL run an 18-bit free-running refresh counter in all states; sel = refresh[17:16].
REQ-017 SHALL drive an in SCROLL and PAUSE as:
- sel=0 gives 4'b0111, sel=1 gives 4'b1011, sel=2 gives 4'b1101, sel=3 gives 4'b1110;
- digit k = sel shows buf[(pos+k) mod msg_len], so messages shorter than 4 repeat.
REQ-018 SHALL drive an=4'b1111 and digit_nib=0 in IDLE and LOAD.
REQ-019 SHALL register an and digit_nib, giving one cycle of latency from sel/pos to the output.
REQ-020 SHALL set active=1 exactly in SCROLL and PAUSE.

Reset
REQ-021 SHALL, while reset_n=0, force:
- state IDLE;
- pos=0, msg_len=0, wr_ptr=0, prescaler=0, refresh=0;
- scroll_tick=0, active=0, an=4'b1111, digit_nib=0.
REQ-022 SHALL make wr_ready=1 on the first cycle after reset_n deasserts.
REQ-023 SHALL, when reset is asserted mid-LOAD or mid-SCROLL, lose the message, with all outputs at REQ-021 values.

Verification (DVSR=4, N=10)
REQ-024 SHALL cover load and scroll: write 1,2,3,4,5 (last on 5) with run=1, dir=0 -> active=1; scroll_tick every 4 cycles; pos sequence 0,1,2,3,4,0.
REQ-025 SHALL cover retreat wrap: same message, dir=1 from pos=0 -> next tick gives pos=4; digit 0 shows 5 and digit 3 shows 3.
REQ-026 SHALL cover overflow: write 10 nibbles with wr_last=0 -> msg_len=10, wr_ready=0 after the 10th write, 11th wr_valid not accepted.
REQ-027 SHALL cover pause and step: run=0 with two step pulses -> pos advances by exactly 2 and no scroll_tick; run=1 -> first tick arrives after the held prescaler remainder.
REQ-028 SHALL cover short message: msg_len=2 (A,B) with pos=0 -> digits 0..3 show A,B,A,B.
REQ-029 SHALL cover priorities: clear asserted in the same cycle as scroll_tick -> next cycle in IDLE with pos=0, an=4'b1111, wr_ready=1; reset_n pulsed mid-LOAD -> all REQ-021 values.
